// File: rtl/kiwih_tt_qtcore_pkg.sv
// Shared definitions for the qtcore-A1 style scan-chain processor.
// Holds state encodings, opcodes, chain length and field offsets.
package kiwih_tt_qtcore_pkg;

    localparam int CHAIN_LEN = 152;
    localparam int MEM_DEPTH = 16;
    localparam int PC_W      = 5;

    localparam int STATE_OFS = 0;
    localparam int PC_OFS    = 3;
    localparam int IR_OFS    = 8;
    localparam int ACC_OFS   = 16;
    localparam int MEM_OFS   = 24;

    typedef enum logic [2:0] {
        ST_FETCH = 3'b001,
        ST_EXEC  = 3'b010,
        ST_HALT  = 3'b100
    } state_t;

    typedef enum logic [3:0] {
        OP_LDA  = 4'h0,
        OP_STA  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_JMP  = 4'h7,
        OP_BZ   = 4'h8,
        OP_BNZ  = 4'h9,
        OP_ADDI = 4'hE,
        OP_MISC = 4'hF
    } opcode_t;

    localparam logic [3:0] MISC_CLR = 4'h0;
    localparam logic [3:0] MISC_NOT = 4'h1;
    localparam logic [3:0] MISC_SHL = 4'h2;
    localparam logic [3:0] MISC_SHR = 4'h3;
    localparam logic [3:0] MISC_HLT = 4'hF;

endpackage

// File: rtl/kiwih_tt_qtcore_scan_reg.sv
// Register with parallel load and serial scan shift; scan has priority over load.
// LSB sits nearest scan_in, MSB drives scan_out.
module kiwih_tt_qtcore_scan_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_en,
    input  logic             load_en,
    input  logic [WIDTH-1:0] d,
    input  logic             scan_in,
    output logic [WIDTH-1:0] q,
    output logic             scan_out
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= RST_VAL;
        else if (scan_en)
            q <= {q[WIDTH-2:0], scan_in};
        else if (load_en)
            q <= d;
    end

    assign scan_out = q[WIDTH-1];

endmodule

// File: rtl/kiwih_tt_qtcore.sv
// Tiny-Tapeout top: 8-bit accumulator core whose whole state is one 152-bit scan chain.
// Pin decode, FETCH/EXEC/HALT sequencing and ALU live here; storage is in scan_reg instances.
module kiwih_tt_qtcore
    import kiwih_tt_qtcore_pkg::*;
(
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic clk, rst, scan_en, run_en, scan_in, scan_out, halt_out;
    assign clk     = io_in[0];
    assign rst     = io_in[1];
    assign scan_en = ~io_in[2];
    assign run_en  = ~io_in[3];
    assign scan_in = io_in[4];

    logic unused_io;
    assign unused_io = ^io_in[7:5];

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d, acc_q, acc_d, operand;
    logic [7:0]      mem_q [MEM_DEPTH];
    logic [7:0]      mem_d [MEM_DEPTH];
    logic            st_we;
    logic            so_state, so_pc, so_ir;
    logic [MEM_DEPTH:0] mem_link;

    kiwih_tt_qtcore_scan_reg #(.WIDTH(3), .RST_VAL(ST_FETCH)) u_state (
        .clk(clk), .rst(rst), .scan_en(scan_en), .load_en(run_en),
        .d(state_d), .scan_in(scan_in), .q(state_q), .scan_out(so_state));

    kiwih_tt_qtcore_scan_reg #(.WIDTH(PC_W), .RST_VAL('0)) u_pc (
        .clk(clk), .rst(rst), .scan_en(scan_en), .load_en(run_en),
        .d(pc_d), .scan_in(so_state), .q(pc_q), .scan_out(so_pc));

    kiwih_tt_qtcore_scan_reg #(.WIDTH(8), .RST_VAL('0)) u_ir (
        .clk(clk), .rst(rst), .scan_en(scan_en), .load_en(run_en),
        .d(ir_d), .scan_in(so_pc), .q(ir_q), .scan_out(so_ir));

    kiwih_tt_qtcore_scan_reg #(.WIDTH(8), .RST_VAL('0)) u_acc (
        .clk(clk), .rst(rst), .scan_en(scan_en), .load_en(run_en),
        .d(acc_d), .scan_in(so_ir), .q(acc_q), .scan_out(mem_link[0]));

    for (genvar k = 0; k < MEM_DEPTH; k++) begin : g_mem
        kiwih_tt_qtcore_scan_reg #(.WIDTH(8), .RST_VAL('0)) u_byte (
            .clk(clk), .rst(rst), .scan_en(scan_en), .load_en(run_en),
            .d(mem_d[k]), .scan_in(mem_link[k]), .q(mem_q[k]), .scan_out(mem_link[k+1]));
    end

    assign scan_out = mem_link[MEM_DEPTH];
    assign operand  = mem_q[ir_q[3:0]];

    // Next-state decode; illegal state codes fall into default and hold like HALT
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        st_we   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_d    = mem_q[pc_q[3:0]];
                pc_d    = pc_q + 5'd1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (opcode_t'(ir_q[7:4]))
                    OP_LDA:  acc_d = operand;
                    OP_STA:  st_we = 1'b1;
                    OP_ADD:  acc_d = acc_q + operand;
                    OP_SUB:  acc_d = acc_q - operand;
                    OP_AND:  acc_d = acc_q & operand;
                    OP_OR:   acc_d = acc_q | operand;
                    OP_XOR:  acc_d = acc_q ^ operand;
                    OP_JMP:  pc_d = {1'b0, ir_q[3:0]};
                    OP_BZ:   if (acc_q == 8'd0) pc_d = {1'b0, ir_q[3:0]};
                    OP_BNZ:  if (acc_q != 8'd0) pc_d = {1'b0, ir_q[3:0]};
                    OP_ADDI: acc_d = acc_q + {4'h0, ir_q[3:0]};
                    OP_MISC: begin
                        case (ir_q[3:0])
                            MISC_CLR: acc_d = 8'd0;
                            MISC_NOT: acc_d = ~acc_q;
                            MISC_SHL: acc_d = {acc_q[6:0], 1'b0};
                            MISC_SHR: acc_d = {1'b0, acc_q[7:1]};
                            MISC_HLT: state_d = ST_HALT;
                            default:  ;
                        endcase
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        for (int k = 0; k < MEM_DEPTH; k++)
            mem_d[k] = (st_we && ir_q[3:0] == 4'(k)) ? acc_q : mem_q[k];
    end

    assign halt_out = (state_q == ST_HALT);
    assign io_out   = {scan_out, halt_out, 6'b000000};

endmodule

// File: tb/tb_kiwih_tt_qtcore.sv
// Scoreboard bench for kiwih_tt_qtcore: every scan unload is compared against a
// reference ISA model of the chain image pushed when the scan operation starts.
module tb_kiwih_tt_qtcore;
    import kiwih_tt_qtcore_pkg::*;

    logic       clk = 1'b0;
    logic       rst, scan_en_n, proc_en_n, scan_in;
    logic [7:0] io_in, io_out;
    logic       scan_out, halt_out;

    assign io_in    = {3'b000, scan_in, proc_en_n, scan_en_n, rst, clk};
    assign scan_out = io_out[7];
    assign halt_out = io_out[6];

    kiwih_tt_qtcore dut (.io_in(io_in), .io_out(io_out));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CHAIN_LEN-1:0] model;
    logic [CHAIN_LEN-1:0] exp_q [$];

    localparam logic [CHAIN_LEN-1:0] RESET_IMG = {128'h0, 8'h00, 8'h00, 5'd0, 3'b001};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CHAIN_LEN-1:0] mk(input logic [2:0] st, input logic [4:0] pc,
                                                input logic [7:0] ir, input logic [7:0] acc,
                                                input logic [127:0] mem);
        return {mem, acc, ir, pc, st};
    endfunction

    // Reference ISA interpreter working on a packed chain image
    function automatic logic [CHAIN_LEN-1:0] step(input logic [CHAIN_LEN-1:0] im);
        logic [2:0]   st;
        logic [4:0]   pc;
        logic [7:0]   ir, acc, opd;
        logic [127:0] mem;
        st  = im[2:0];
        pc  = im[7:3];
        ir  = im[15:8];
        acc = im[23:16];
        mem = im[151:24];
        if (st == 3'b001) begin
            ir = mem[int'(pc[3:0])*8 +: 8];
            pc = pc + 5'd1;
            st = 3'b010;
        end else if (st == 3'b010) begin
            st  = 3'b001;
            opd = mem[int'(ir[3:0])*8 +: 8];
            case (ir[7:4])
                4'h0: acc = opd;
                4'h1: mem[int'(ir[3:0])*8 +: 8] = acc;
                4'h2: acc = acc + opd;
                4'h3: acc = acc - opd;
                4'h4: acc = acc & opd;
                4'h5: acc = acc | opd;
                4'h6: acc = acc ^ opd;
                4'h7: pc = {1'b0, ir[3:0]};
                4'h8: if (acc == 8'd0) pc = {1'b0, ir[3:0]};
                4'h9: if (acc != 8'd0) pc = {1'b0, ir[3:0]};
                4'hE: acc = acc + {4'h0, ir[3:0]};
                4'hF: begin
                    case (ir[3:0])
                        4'h0: acc = 8'd0;
                        4'h1: acc = ~acc;
                        4'h2: acc = acc << 1;
                        4'h3: acc = acc >> 1;
                        4'hF: st = 3'b100;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
        return {mem, acc, ir, pc, st};
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cmp_image(input logic [CHAIN_LEN-1:0] exp, input logic [CHAIN_LEN-1:0] got);
        chk("state", 32'(got[STATE_OFS +: 3]), 32'(exp[STATE_OFS +: 3]));
        chk("pc",    32'(got[PC_OFS +: 5]),    32'(exp[PC_OFS +: 5]));
        chk("ir",    32'(got[IR_OFS +: 8]),    32'(exp[IR_OFS +: 8]));
        chk("acc",   32'(got[ACC_OFS +: 8]),   32'(exp[ACC_OFS +: 8]));
        for (int k = 0; k < MEM_DEPTH; k++)
            chk($sformatf("mem%0d", k), 32'(got[MEM_OFS + 8*k +: 8]), 32'(exp[MEM_OFS + 8*k +: 8]));
    endtask

    // Full 152-edge scan: unloads the old image while loading nimg
    task automatic scan(input logic [CHAIN_LEN-1:0] nimg, input logic run_too);
        logic [CHAIN_LEN-1:0] cap;
        exp_q.push_back(model);
        scan_en_n = 1'b0;
        proc_en_n = ~run_too;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            cap[CHAIN_LEN-1-i] = scan_out;
            scan_in = nimg[CHAIN_LEN-1-i];
            cycle();
        end
        scan_en_n = 1'b1;
        proc_en_n = 1'b1;
        model = nimg;
        cmp_image(exp_q.pop_front(), cap);
    endtask

    task automatic run(input int n);
        proc_en_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            model = step(model);
            cycle();
            chk("halt_out", 32'(halt_out), 32'(model[2:0] == 3'b100));
        end
        proc_en_n = 1'b1;
    endtask

    initial begin
        rst = 1'b0; scan_en_n = 1'b1; proc_en_n = 1'b1; scan_in = 1'b0;
        model = '0;
        @(negedge clk);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        model = RESET_IMG;
        chk("halt_rst", 32'(halt_out), 32'd0);

        scan(mk(3'b001, 5'd1, 8'hE0, 8'h01, {88'h0, 8'hE4, 8'hE3, 8'hE2, 8'hE1, 8'hE0}), 1'b0);
        run(8);
        repeat (3) cycle();
        scan('0, 1'b0);
        run(2);

        scan(mk(3'b001, 5'd1, 8'h00, 8'h03, {8'h05, 88'h0, 8'hFF, 8'h1E, 8'h2F, 8'h01}), 1'b0);
        run(8);
        run(4);

        scan(mk(3'b001, 5'd0, 8'h00, 8'h00, {120'h0, 8'h84}), 1'b0);
        run(2);
        scan(mk(3'b001, 5'd0, 8'h00, 8'h01, {120'h0, 8'h84}), 1'b0);
        run(2);
        scan(mk(3'b001, 5'd2, 8'h00, 8'h11, {96'h0, 8'h1F, 8'h3D, 8'hF2, 8'h6C}), 1'b1);

        rst = 1'b1; scan_en_n = 1'b0; proc_en_n = 1'b0; scan_in = 1'b1;
        cycle();
        rst = 1'b0; scan_en_n = 1'b1; proc_en_n = 1'b1;
        model = RESET_IMG;
        scan(mk(3'b001, 5'd3, 8'hA5, 8'h5A, {64'h0123456789ABCDEF, 64'hFEDCBA9876543210}), 1'b0);

        scan_en_n = 1'b0; proc_en_n = 1'b0; scan_in = 1'b1;
        cycle();
        scan_en_n = 1'b1; proc_en_n = 1'b1;
        model = {model[CHAIN_LEN-2:0], 1'b1};
        scan(mk(3'b001, 5'd0, 8'h00, 8'h77, {64'h0, 64'hF3F2F1F0_93E2A1F8}), 1'b0);

        scan_en_n = 1'b0; scan_in = 1'b1;
        repeat (50) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; scan_en_n = 1'b1;
        model = RESET_IMG;

        for (int r = 0; r < 4; r++) begin
            scan(mk(3'b001, 5'($urandom), 8'($urandom), 8'($urandom),
                    {$urandom, $urandom, $urandom, $urandom}), 1'b0);
            run(20);
        end
        scan('0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
